// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between the in-order pipeline
// write-back (always wins) and a FIFO of buffered long-latency unit results.
module regfile_wr_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_we,
    input  logic [4:0]                 pipe_addr,
    input  logic [31:0]                pipe_data,
    input  logic                       lu_valid,
    input  logic [4:0]                 lu_addr,
    input  logic [31:0]                lu_data,
    output logic                       lu_ready,
    output logic                       rf_we,
    output logic [4:0]                 rf_addr,
    output logic [31:0]                rf_data,
    output logic                       stall_req,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;

    logic pipe_use, full, push, fifo_grant;

    assign pipe_use   = pipe_we && (pipe_addr != 5'd0);
    assign full       = (count == CW'(DEPTH));
    // Outputs are gated by rst so they read as idle while reset is held.
    assign lu_ready   = rst && !full;
    assign push       = lu_valid && lu_ready;
    assign fifo_grant = rst && !pipe_use && (count != '0);
    assign stall_req  = rst && (starve_cnt == SW'(STARVE_LIMIT));
    assign fifo_count = rst ? count : '0;

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (rst && pipe_use) begin
            rf_we   = 1'b1;
            rf_addr = pipe_addr;
            rf_data = pipe_data;
        end else if (fifo_grant) begin
            rf_we   = 1'b1;
            rf_addr = mem[rd_ptr].addr;
            rf_data = mem[rd_ptr].data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{addr: lu_addr, data: lu_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (fifo_grant)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(fifo_grant);
            // Counts cycles the head has been denied; saturates so stall_req holds.
            if (count == '0 || fifo_grant)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed vector table plus a push/pop pointer-wrap sequence for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        stall_req;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    regfile_wr_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data),
        .lu_ready(lu_ready), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .stall_req(stall_req), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_stall;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic r, input logic pwe, input logic [4:0] pa,
                                input logic [31:0] pd, input logic lv, input logic [4:0] la,
                                input logic [31:0] ld, input logic e_rdy, input logic e_we,
                                input logic [4:0] e_addr, input logic [31:0] e_data,
                                input logic e_stall, input logic [2:0] e_cnt);
        vec_t v;
        v.rst = r; v.pwe = pwe; v.pa = pa; v.pd = pd; v.lv = lv; v.la = la; v.ld = ld;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
        v.e_stall = e_stall; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic pwe, input logic [4:0] pa,
                         input logic [31:0] pd, input logic lv, input logic [4:0] la,
                         input logic [31:0] ld);
        rst = r; pipe_we = pwe; pipe_addr = pa; pipe_data = pd;
        lu_valid = lv; lu_addr = la; lu_data = ld;
    endtask

    initial begin
        logic [4:0]  qa[$];
        logic [31:0] qd[$];

        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        //            rst pwe pa  pd           lv  la  ld            rdy we addr data          st cnt
        // reset held with activity on the inputs
        tv.push_back(mk(0, 1, 3, 32'h1,        1, 1, 32'h9,         0, 0, 0, 32'h0,        0, 0));
        tv.push_back(mk(0, 1, 3, 32'h1,        1, 1, 32'h9,         0, 0, 0, 32'h0,        0, 0));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 0, 0, 32'h0,        0, 0));
        // idle drain, no bypass
        tv.push_back(mk(1, 0, 0, 32'h0,        1, 7, 32'hDEADBEEF,  1, 0, 0, 32'h0,        0, 0));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 7, 32'hDEADBEEF, 0, 1));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 0, 0, 32'h0,        0, 0));
        // priority, then pipeline x0 write lets the FIFO through
        tv.push_back(mk(1, 0, 0, 32'h0,        1, 5, 32'h11,        1, 0, 0, 32'h0,        0, 0));
        tv.push_back(mk(1, 1, 3, 32'h22,       0, 0, 32'h0,         1, 1, 3, 32'h22,       0, 1));
        tv.push_back(mk(1, 1, 0, 32'h33,       0, 0, 32'h0,         1, 1, 5, 32'h11,       0, 1));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 0, 0, 32'h0,        0, 0));
        // fill to full under pipeline traffic; 5th push refused
        tv.push_back(mk(1, 1, 1, 32'h100,      1, 10, 32'hA,        1, 1, 1, 32'h100,      0, 0));
        tv.push_back(mk(1, 1, 1, 32'h101,      1, 11, 32'hB,        1, 1, 1, 32'h101,      0, 1));
        tv.push_back(mk(1, 1, 1, 32'h102,      1, 12, 32'hC,        1, 1, 1, 32'h102,      0, 2));
        tv.push_back(mk(1, 1, 1, 32'h103,      1, 13, 32'hD,        1, 1, 1, 32'h103,      0, 3));
        tv.push_back(mk(1, 1, 1, 32'h104,      1, 14, 32'hE,        0, 1, 1, 32'h104,      0, 4));
        // contract violation: pipeline still wins, stall held
        tv.push_back(mk(1, 1, 1, 32'h105,      1, 14, 32'hE,        0, 1, 1, 32'h105,      1, 4));
        // full + popping still refuses the push
        tv.push_back(mk(1, 0, 0, 32'h0,        1, 14, 32'hE,        0, 1, 10, 32'hA,       1, 4));
        tv.push_back(mk(1, 0, 0, 32'h0,        1, 14, 32'hE,        1, 1, 11, 32'hB,       0, 3));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 12, 32'hC,       0, 3));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 13, 32'hD,       0, 2));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 14, 32'hE,       0, 1));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 0, 0, 32'h0,        0, 0));
        // starvation: 4 denied cycles, stall in 5th, bubble in 6th, clear in 7th
        tv.push_back(mk(1, 0, 0, 32'h0,        1, 6, 32'h66,        1, 0, 0, 32'h0,        0, 0));
        tv.push_back(mk(1, 1, 2, 32'h200,      0, 0, 32'h0,         1, 1, 2, 32'h200,      0, 1));
        tv.push_back(mk(1, 1, 2, 32'h201,      0, 0, 32'h0,         1, 1, 2, 32'h201,      0, 1));
        tv.push_back(mk(1, 1, 2, 32'h202,      0, 0, 32'h0,         1, 1, 2, 32'h202,      0, 1));
        tv.push_back(mk(1, 1, 2, 32'h203,      0, 0, 32'h0,         1, 1, 2, 32'h203,      0, 1));
        tv.push_back(mk(1, 1, 2, 32'h204,      0, 0, 32'h0,         1, 1, 2, 32'h204,      1, 1));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 6, 32'h66,       1, 1));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 0, 0, 32'h0,        0, 0));
        // reset mid-operation flushes the FIFO
        tv.push_back(mk(1, 1, 4, 32'h44,       1, 9, 32'h99,        1, 1, 4, 32'h44,       0, 0));
        tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0, 32'h0,        0, 0));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 0, 0, 32'h0,        0, 0));
        // x0 FIFO entry drains as a harmless write
        tv.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h55,        1, 0, 0, 32'h0,        0, 0));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 0, 32'h55,       0, 1));
        tv.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 0, 0, 32'h0,        0, 0));
        // pipeline x0 with empty FIFO writes nothing
        tv.push_back(mk(1, 1, 0, 32'h77,       0, 0, 32'h0,         1, 0, 0, 32'h0,        0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].pwe, tv[i].pa, tv[i].pd, tv[i].lv, tv[i].la, tv[i].ld);
            #1;
            chk("lu_ready",   i, 32'(lu_ready),   32'(tv[i].e_rdy));
            chk("rf_we",      i, 32'(rf_we),      32'(tv[i].e_we));
            chk("rf_addr",    i, 32'(rf_addr),    32'(tv[i].e_addr));
            chk("rf_data",    i, rf_data,         tv[i].e_data);
            chk("stall_req",  i, 32'(stall_req),  32'(tv[i].e_stall));
            chk("fifo_count", i, 32'(fifo_count), 32'(tv[i].e_cnt));
        end

        // Preload two entries behind pipeline traffic, then push+pop every cycle.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 5'd1, 32'h0, 1'b1, 5'(16 + i), 32'hC000 + 32'(i));
            qa.push_back(5'(16 + i));
            qd.push_back(32'hC000 + 32'(i));
        end
        for (int i = 2; i < 12; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(16 + i), 32'hC000 + 32'(i));
            #1;
            chk("wrap_we",    i, 32'(rf_we),      32'd1);
            chk("wrap_addr",  i, 32'(rf_addr),    32'(qa[0]));
            chk("wrap_data",  i, rf_data,         qd[0]);
            chk("wrap_count", i, 32'(fifo_count), 32'd2);
            void'(qa.pop_front());
            void'(qd.pop_front());
            qa.push_back(5'(16 + i));
            qd.push_back(32'hC000 + 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            #1;
            chk("tail_addr",  i, 32'(rf_addr),    32'(qa[0]));
            chk("tail_data",  i, rf_data,         qd[0]);
            chk("tail_count", i, 32'(fifo_count), 32'(2 - i));
            void'(qa.pop_front());
            void'(qd.pop_front());
        end
        @(negedge clk);
        #1;
        chk("empty_count", 0, 32'(fifo_count), 32'd0);
        chk("empty_we",    0, 32'(rf_we),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
